// File: rtl/ioctl_mem_writer.sv
// Packs the 8-bit ioctl download stream into 16-bit words with byte enables,
// buffers them in a small FIFO and writes them out over a level req/ack handshake.
`timescale 1ns/1ps
module ioctl_mem_writer #(
  parameter logic [7:0]        INDEX     = 8'h00,
  parameter int                ADDR_W    = 24,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
  parameter int                FIFO_AW   = 3
) (
  input  logic              clk_sys,
  input  logic              reset,
  input  logic              ioctl_download,
  input  logic [7:0]        ioctl_index,
  input  logic              ioctl_wr,
  input  logic [26:0]       ioctl_addr,
  input  logic [7:0]        ioctl_dout,
  output logic              clkref_n,
  output logic              mem_req,
  input  logic              mem_ack,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [15:0]       mem_din,
  output logic [1:0]        mem_be,
  output logic              busy,
  output logic              done,
  output logic              overflow,
  output logic [26:0]       byte_count
);

  localparam int DEPTH = 1 << FIFO_AW;
  localparam int EW    = ADDR_W + 18;
  localparam logic [FIFO_AW:0] CNT_FULL = (FIFO_AW+1)'(DEPTH);
  localparam logic [FIFO_AW:0] CNT_TH   = (FIFO_AW+1)'(DEPTH - 3);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_FLUSH} state_t;

  state_t r_state, w_nextState;
  logic   r_dlPrev;

  logic [EW-1:0]      r_fifo [DEPTH];
  logic [FIFO_AW-1:0] r_wrPtr, r_rdPtr;
  logic [FIFO_AW:0]   r_count;

  logic              r_pendValid;
  logic [ADDR_W-1:0] r_pendAddr;
  logic [15:0]       r_pendData;
  logic [1:0]        r_pendBe;

  logic              r_memReq;
  logic [ADDR_W-1:0] r_memAddr;
  logic [15:0]       r_memDin;
  logic [1:0]        r_memBe;
  logic              r_done, r_overflow, r_clkref;
  logic [26:0]       r_byteCount;

  logic              w_rise, w_fall, w_loadEntry, w_finish;
  logic              w_wrAcc, w_odd, w_push, w_pop, w_full, w_drop, w_pushOk;
  logic [ADDR_W-1:0] w_wordAddr;
  logic [EW-1:0]     w_pendEntry, w_pushEntry;
  logic              w_pendValidN;
  logic [ADDR_W-1:0] w_pendAddrN;
  logic [15:0]       w_pendDataN;
  logic [1:0]        w_pendBeN;

  assign w_rise      = ioctl_download & ~r_dlPrev;
  assign w_fall      = ~ioctl_download & r_dlPrev;
  assign w_wrAcc     = (r_state == S_LOAD) && ioctl_wr;
  assign w_odd       = ioctl_addr[0];
  assign w_wordAddr  = BASE_ADDR + ADDR_W'(ioctl_addr[26:1]);
  assign w_pendEntry = {r_pendAddr, r_pendData, r_pendBe};

  always_comb begin
    w_nextState = r_state;
    w_loadEntry = 1'b0;
    w_finish    = 1'b0;
    case (r_state)
      S_IDLE:
        if (w_rise && (ioctl_index == INDEX)) begin
          w_nextState = S_LOAD;
          w_loadEntry = 1'b1;
        end
      S_LOAD:
        if (w_fall) w_nextState = S_FLUSH;
      S_FLUSH:
        if (!r_pendValid && (r_count == '0) && !r_memReq) begin
          w_nextState = S_IDLE;
          w_finish    = 1'b1;
        end
      default: w_nextState = S_IDLE;
    endcase
  end

  // A lone odd byte that cannot be pushed this cycle is parked as pending with
  // be=10 and pushed on the next cycle, so there is never more than one push per cycle.
  always_comb begin
    w_push       = 1'b0;
    w_pushEntry  = w_pendEntry;
    w_pendValidN = r_pendValid;
    w_pendAddrN  = r_pendAddr;
    w_pendDataN  = r_pendData;
    w_pendBeN    = r_pendBe;
    if (w_wrAcc) begin
      if (!w_odd) begin
        w_push       = r_pendValid;
        w_pendValidN = 1'b1;
        w_pendAddrN  = w_wordAddr;
        w_pendDataN  = {8'h00, ioctl_dout};
        w_pendBeN    = 2'b01;
      end else if (r_pendValid && (r_pendBe == 2'b01) && (r_pendAddr == w_wordAddr)) begin
        w_push       = 1'b1;
        w_pushEntry  = {w_wordAddr, ioctl_dout, r_pendData[7:0], 2'b11};
        w_pendValidN = 1'b0;
      end else if (r_pendValid) begin
        w_push       = 1'b1;
        w_pendValidN = 1'b1;
        w_pendAddrN  = w_wordAddr;
        w_pendDataN  = {ioctl_dout, 8'h00};
        w_pendBeN    = 2'b10;
      end else begin
        w_push       = 1'b1;
        w_pushEntry  = {w_wordAddr, ioctl_dout, 8'h00, 2'b10};
      end
    end else if (r_pendValid && ((r_pendBe == 2'b10) || (r_state == S_FLUSH))) begin
      w_push       = 1'b1;
      w_pendValidN = 1'b0;
    end
  end

  assign w_pop    = !r_memReq && (r_count != '0);
  assign w_full   = (r_count == CNT_FULL);
  assign w_drop   = w_push && w_full && !w_pop;
  assign w_pushOk = w_push && !w_drop;

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_dlPrev <= 1'b0;
    end else begin
      r_state  <= w_nextState;
      r_dlPrev <= ioctl_download;
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset || w_loadEntry) begin
      r_pendValid <= 1'b0;
      r_pendAddr  <= '0;
      r_pendData  <= '0;
      r_pendBe    <= '0;
    end else begin
      r_pendValid <= w_pendValidN;
      r_pendAddr  <= w_pendAddrN;
      r_pendData  <= w_pendDataN;
      r_pendBe    <= w_pendBeN;
    end
  end

  always_ff @(posedge clk_sys) begin
    if (w_pushOk) r_fifo[r_wrPtr] <= w_pushEntry;
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_pushOk) r_wrPtr <= r_wrPtr + 1'b1;
      if (w_pop)    r_rdPtr <= r_rdPtr + 1'b1;
      case ({w_pushOk, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // The request payload is captured at pop time and held until the ack.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      r_memReq  <= 1'b0;
      r_memAddr <= '0;
      r_memDin  <= '0;
      r_memBe   <= '0;
    end else if (w_pop) begin
      r_memReq                       <= 1'b1;
      {r_memAddr, r_memDin, r_memBe} <= r_fifo[r_rdPtr];
    end else if (r_memReq && mem_ack) begin
      r_memReq <= 1'b0;
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      r_done      <= 1'b0;
      r_overflow  <= 1'b0;
      r_clkref    <= 1'b0;
      r_byteCount <= '0;
    end else begin
      r_done   <= w_finish;
      r_clkref <= (w_nextState != S_IDLE) && (r_count >= CNT_TH);
      if (w_loadEntry) begin
        r_overflow  <= 1'b0;
        r_byteCount <= '0;
      end else begin
        if (w_drop)             r_overflow  <= 1'b1;
        if (w_wrAcc && !w_drop) r_byteCount <= r_byteCount + 27'd1;
      end
    end
  end

  assign clkref_n   = r_clkref;
  assign mem_req    = r_memReq;
  assign mem_addr   = r_memAddr;
  assign mem_din    = r_memDin;
  assign mem_be     = r_memBe;
  assign busy       = (r_state != S_IDLE);
  assign done       = r_done;
  assign overflow   = r_overflow;
  assign byte_count = r_byteCount;

endmodule

// File: tb/tb_ioctl_mem_writer.sv
// Scoreboard bench for ioctl_mem_writer: directed downloads, expected writes queued
// up front and popped by a monitor on every new mem_req.
`timescale 1ns/1ps
module tb_ioctl_mem_writer;

  localparam logic [7:0]  IDX  = 8'h03;
  localparam logic [23:0] BASE = 24'h000100;

  logic        clk_sys = 1'b0;
  logic        reset = 1'b1;
  logic        ioctl_download = 1'b0;
  logic [7:0]  ioctl_index = 8'h00;
  logic        ioctl_wr = 1'b0;
  logic [26:0] ioctl_addr = '0;
  logic [7:0]  ioctl_dout = 8'h00;
  logic        clkref_n;
  logic        mem_req;
  logic        mem_ack = 1'b0;
  logic [23:0] mem_addr;
  logic [15:0] mem_din;
  logic [1:0]  mem_be;
  logic        busy, done, overflow;
  logic [26:0] byte_count;

  typedef struct packed {
    logic [23:0] addr;
    logic [15:0] din;
    logic [1:0]  be;
  } wr_t;

  wr_t expQ[$];
  int  nChecks = 0;
  int  nFails = 0;
  int  doneCount = 0;
  int  ackDelay = 1;
  int  waitCnt = 0;
  bit  clkrefSeen = 1'b0;

  ioctl_mem_writer #(
    .INDEX(IDX), .ADDR_W(24), .BASE_ADDR(BASE), .FIFO_AW(3)
  ) dut (
    .clk_sys(clk_sys), .reset(reset),
    .ioctl_download(ioctl_download), .ioctl_index(ioctl_index),
    .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout),
    .clkref_n(clkref_n), .mem_req(mem_req), .mem_ack(mem_ack),
    .mem_addr(mem_addr), .mem_din(mem_din), .mem_be(mem_be),
    .busy(busy), .done(done), .overflow(overflow), .byte_count(byte_count)
  );

  always #5 clk_sys = ~clk_sys;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    nChecks++;
    if (actual !== expected) begin
      nFails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic reportFail(input string name);
    nChecks++;
    nFails++;
    $display("[TB] FAIL %s", name);
  endtask

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic expectWrite(input logic [23:0] a, input logic [15:0] d, input logic [1:0] be);
    wr_t e;
    e.addr = a;
    e.din  = d;
    e.be   = be;
    expQ.push_back(e);
  endtask

  // One byte strobe, honouring the clkref_n throttle like the real downloader
  task automatic applyStimulus(input logic [26:0] addr, input logic [7:0] data);
    int guard;
    guard = 0;
    while (clkref_n && guard < 2000) begin
      tick();
      guard++;
    end
    if (clkref_n) reportFail("clkref_n stall timeout");
    ioctl_wr   = 1'b1;
    ioctl_addr = addr;
    ioctl_dout = data;
    tick();
    ioctl_wr   = 1'b0;
  endtask

  task automatic startDownload(input logic [7:0] idx);
    ioctl_index    = idx;
    ioctl_download = 1'b1;
    tick();
  endtask

  task automatic endDownload();
    ioctl_download = 1'b0;
    tick();
  endtask

  task automatic waitDone(input string name, input int startCount, input int limit);
    int n;
    n = 0;
    while (doneCount == startCount && n < limit) begin
      tick();
      n++;
    end
    if (doneCount == startCount) reportFail({name, " done timeout"});
    repeat (4) tick();
    checkOutput({name, " done pulses"}, 64'(doneCount), 64'(startCount + 1));
  endtask

  // Memory controller: acks each request ackDelay cycles after it is seen
  initial begin
    forever begin
      @(posedge clk_sys);
      #1;
      if (reset) begin
        mem_ack = 1'b0;
        waitCnt = 0;
      end else if (mem_ack) begin
        mem_ack = 1'b0;
      end else if (mem_req) begin
        if (waitCnt >= ackDelay) begin
          mem_ack = 1'b1;
          waitCnt = 0;
        end else begin
          waitCnt++;
        end
      end else begin
        waitCnt = 0;
      end
    end
  end

  // Monitor: compare every new request against the scoreboard, and hold stability
  initial begin
    logic        prevReq;
    wr_t         e;
    logic [41:0] held;
    logic [15:0] mask;
    prevReq = 1'b0;
    held    = '0;
    forever begin
      @(negedge clk_sys);
      if (done) doneCount++;
      if (clkref_n) clkrefSeen = 1'b1;
      if (mem_req && !prevReq) begin
        if (expQ.size() == 0) begin
          reportFail($sformatf("unexpected write addr=0x%0h din=0x%0h be=%0b", mem_addr, mem_din, mem_be));
        end else begin
          e    = expQ.pop_front();
          mask = {{8{e.be[1]}}, {8{e.be[0]}}};
          checkOutput("write addr", 64'(mem_addr), 64'(e.addr));
          checkOutput("write be", 64'(mem_be), 64'(e.be));
          checkOutput("write din", 64'(mem_din & mask), 64'(e.din & mask));
        end
        held = {mem_addr, mem_din, mem_be};
      end else if (mem_req && prevReq) begin
        checkOutput("req payload stable", 64'({mem_addr, mem_din, mem_be}), 64'(held));
      end
      prevReq = mem_req;
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL global timeout");
    $fatal(1, "[TB] simulation did not finish");
  end

  initial begin
    int d0;
    int guard;
    $display("[TB] start");
    repeat (3) tick();
    checkOutput("reset clkref_n", 64'(clkref_n), 64'(0));
    checkOutput("reset mem_req", 64'(mem_req), 64'(0));
    checkOutput("reset mem_addr", 64'(mem_addr), 64'(0));
    checkOutput("reset mem_din", 64'(mem_din), 64'(0));
    checkOutput("reset mem_be", 64'(mem_be), 64'(0));
    checkOutput("reset busy", 64'(busy), 64'(0));
    checkOutput("reset done", 64'(done), 64'(0));
    checkOutput("reset overflow", 64'(overflow), 64'(0));
    checkOutput("reset byte_count", 64'(byte_count), 64'(0));
    reset = 1'b0;
    tick();

    // Four bytes, two full words
    $display("[TB] test1 aligned 4 bytes");
    expectWrite(BASE + 24'd0, 16'h2211, 2'b11);
    expectWrite(BASE + 24'd1, 16'h4433, 2'b11);
    d0 = doneCount;
    startDownload(IDX);
    checkOutput("t1 busy in LOAD", 64'(busy), 64'(1));
    applyStimulus(27'd0, 8'h11);
    applyStimulus(27'd1, 8'h22);
    applyStimulus(27'd2, 8'h33);
    applyStimulus(27'd3, 8'h44);
    endDownload();
    waitDone("t1", d0, 200);
    checkOutput("t1 byte_count", 64'(byte_count), 64'(4));
    checkOutput("t1 busy after done", 64'(busy), 64'(0));
    checkOutput("t1 writes outstanding", 64'(expQ.size()), 64'(0));
    checkOutput("t1 clkref_n idle", 64'(clkref_n), 64'(0));

    // Odd-length file: last byte flushed alone
    $display("[TB] test2 odd length");
    expectWrite(BASE + 24'd0, 16'hBBAA, 2'b11);
    expectWrite(BASE + 24'd1, 16'h00CC, 2'b01);
    d0 = doneCount;
    startDownload(IDX);
    applyStimulus(27'd0, 8'hAA);
    applyStimulus(27'd1, 8'hBB);
    applyStimulus(27'd2, 8'hCC);
    endDownload();
    waitDone("t2", d0, 200);
    checkOutput("t2 byte_count", 64'(byte_count), 64'(3));
    checkOutput("t2 writes outstanding", 64'(expQ.size()), 64'(0));

    // Start at an odd address, then jump
    $display("[TB] test3 odd start and gap");
    expectWrite(BASE + 24'd2, 16'h5A00, 2'b10);
    expectWrite(BASE + 24'd4, 16'h0077, 2'b01);
    d0 = doneCount;
    startDownload(IDX);
    applyStimulus(27'd5, 8'h5A);
    applyStimulus(27'd8, 8'h77);
    endDownload();
    waitDone("t3", d0, 200);
    checkOutput("t3 byte_count", 64'(byte_count), 64'(2));
    checkOutput("t3 writes outstanding", 64'(expQ.size()), 64'(0));

    // Slow memory with a continuous stream: throttle must engage
    $display("[TB] test4 throttle");
    ackDelay   = 40;
    clkrefSeen = 1'b0;
    for (int i = 0; i < 12; i++)
      expectWrite(BASE + 24'(i), {8'(8'h41 + 2*i), 8'(8'h40 + 2*i)}, 2'b11);
    d0 = doneCount;
    startDownload(IDX);
    for (int j = 0; j < 24; j++)
      applyStimulus(27'(j), 8'(8'h40 + j));
    endDownload();
    waitDone("t4", d0, 3000);
    checkOutput("t4 clkref_n raised", 64'(clkrefSeen), 64'(1));
    checkOutput("t4 overflow", 64'(overflow), 64'(0));
    checkOutput("t4 byte_count", 64'(byte_count), 64'(24));
    checkOutput("t4 writes outstanding", 64'(expQ.size()), 64'(0));
    ackDelay = 1;

    // Foreign index: everything ignored
    $display("[TB] test5 index mismatch");
    d0 = doneCount;
    startDownload(8'h05);
    checkOutput("t5 busy", 64'(busy), 64'(0));
    applyStimulus(27'd0, 8'hE1);
    applyStimulus(27'd1, 8'hE2);
    endDownload();
    repeat (20) tick();
    checkOutput("t5 done count", 64'(doneCount), 64'(d0));
    checkOutput("t5 byte_count", 64'(byte_count), 64'(24));
    checkOutput("t5 busy after", 64'(busy), 64'(0));
    checkOutput("t5 mem_req", 64'(mem_req), 64'(0));

    // Reset while a request is outstanding
    $display("[TB] test6 reset mid-transfer");
    ackDelay = 40;
    expectWrite(BASE + 24'd0, 16'h3412, 2'b11);
    startDownload(IDX);
    applyStimulus(27'd0, 8'h12);
    applyStimulus(27'd1, 8'h34);
    applyStimulus(27'd2, 8'h56);
    applyStimulus(27'd3, 8'h78);
    guard = 0;
    while (!mem_req && guard < 100) begin
      tick();
      guard++;
    end
    checkOutput("t6 req before reset", 64'(mem_req), 64'(1));
    reset          = 1'b1;
    ioctl_download = 1'b0;
    tick();
    checkOutput("t6 mem_req after reset", 64'(mem_req), 64'(0));
    checkOutput("t6 busy after reset", 64'(busy), 64'(0));
    checkOutput("t6 byte_count after reset", 64'(byte_count), 64'(0));
    reset = 1'b0;
    expQ.delete();
    ackDelay = 1;
    repeat (3) tick();
    expectWrite(BASE + 24'd3, 16'h8899, 2'b11);
    d0 = doneCount;
    startDownload(IDX);
    applyStimulus(27'd6, 8'h99);
    applyStimulus(27'd7, 8'h88);
    endDownload();
    waitDone("t6", d0, 200);
    checkOutput("t6 byte_count", 64'(byte_count), 64'(2));
    checkOutput("t6 writes outstanding", 64'(expQ.size()), 64'(0));
    checkOutput("t6 overflow", 64'(overflow), 64'(0));

    repeat (5) tick();
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule

// File: doc/ioctl_mem_writer.md
Name: ioctl_mem_writer

Overview:
- Downstream consumer of the file-download byte stream (ioctl_download / ioctl_wr / ioctl_addr / ioctl_dout, 8-bit mode).
- Packs bytes into 16-bit words with byte enables and buffers them in a small FIFO.
- Issues the words to the SDRAM/BRAM controller over a level req/ack handshake.
- Throttles the downloader through clkref_n and signals completion once every byte is committed to memory.

Parameters:
- INDEX, 8'h00: ioctl_index value this writer accepts. Downloads with any other index are ignored entirely.
- ADDR_W, 24: width of the memory word address.
- BASE_ADDR, 24'h000000: word address added to ioctl_addr[26:1].
- FIFO_AW, 3: log2 of FIFO depth (default 8 entries). Legal range 2..5.

Ports:
- clk_sys, in, 1: system clock; all logic on its rising edge.
- reset, in, 1: synchronous, active-high.
- ioctl_download, in, 1: download active level.
- ioctl_index, in, 8: file index; sampled on the rising edge of ioctl_download.
- ioctl_wr, in, 1: one-cycle byte strobe.
- ioctl_addr, in, 27: byte address of ioctl_dout.
- ioctl_dout, in, 8: byte data.
- clkref_n, out, 1: low = downloader may issue a byte; high = stall.
- mem_req, out, 1: write request level.
- mem_ack, in, 1: one-cycle acceptance from the memory controller.
- mem_addr, out, ADDR_W: word address.
- mem_din, out, 16: write data; even byte in [7:0], odd byte in [15:8].
- mem_be, out, 2: byte enables; [0] = low byte, [1] = high byte.
- busy, out, 1: high in LOAD or FLUSH.
- done, out, 1: one-cycle pulse when a matching download is fully committed.
- overflow, out, 1: sticky flag; a byte was dropped because the FIFO was full.
- byte_count, out, 27: bytes accepted in the current/last download.

Behaviour:
- Reset values: clkref_n=0, mem_req=0, mem_addr=0, mem_din=0, mem_be=0, busy=0, done=0, overflow=0, byte_count=0.
- Reset state: FIFO empty, pending-byte register invalid, state IDLE.
- Reset mid-transfer: mem_req drops the next cycle. The abandoned request is never re-issued. The controller must tolerate a dropped req.

State machine:
- IDLE -> LOAD: on a 0->1 edge of ioctl_download (registered edge detect) with ioctl_index==INDEX. On entry: byte_count=0, overflow=0, pending invalid. Non-matching index stays in IDLE; ioctl_wr is ignored in IDLE.
- LOAD -> FLUSH: on the 1->0 edge of ioctl_download.
- FLUSH -> IDLE: when the pending byte has been pushed, the FIFO is empty and mem_req=0. done pulses for 1 cycle on that transition.

Byte packing (LOAD only):
- Word address = BASE_ADDR + ioctl_addr[26:1], truncated to ADDR_W (wraps modulo 2^ADDR_W).
- Even byte (addr[0]=0): if a pending byte exists, push it first with its be (01 or 10). Then hold the new byte as pending with be=01.
- Odd byte, pending even byte at the same word address: push the combined word with be=11 and clear pending.
- Odd byte, no matching pending: push any existing pending byte alone, then push the odd byte with be=10 and data in [15:8].
- A byte that needs two pushes takes 2 FIFO slots in consecutive cycles. The throttle headroom covers this.
- Entering FLUSH: push any pending byte alone before draining.
- byte_count increments on every accepted ioctl_wr. Dropped bytes are not counted.

FIFO:
- Entry = {word address, data, be}. Depth 2^FIFO_AW.
- Simultaneous push and pop in one cycle is legal; count stays unchanged.
- Push into a full FIFO: entry dropped, overflow set (sticky until the next LOAD entry). Must not occur while the downloader obeys clkref_n.

Throttle:
- clkref_n = registered (count >= DEPTH-3). This keeps 3 slots of headroom for the 1-cycle downloader reaction plus a 2-push byte.
- clkref_n=0 whenever the writer is in IDLE.

Memory handshake:
- When mem_req=0 and the FIFO is not empty: pop the head into mem_addr/mem_din/mem_be and assert mem_req next cycle.
- mem_addr/mem_din/mem_be stay stable while mem_req=1.
- On the mem_ack cycle, mem_req drops the next cycle.
- mem_req may reassert at the earliest 1 cycle after it drops, so one idle cycle separates requests.
- Peak throughput is 1 word per 2 cycles plus controller latency.
- mem_ack while mem_req=0 is ignored.

Test Plan:
- Download with INDEX match, bytes 0x11,0x22,0x33,0x44 at addrs 0..3, mem_ack 1 cycle after each req -> two writes: addr BASE+0 din 0x2211 be 11, addr BASE+1 din 0x4433 be 11. done pulses once after the last ack; byte_count=4.
- Odd-length file of 3 bytes (0xAA,0xBB,0xCC) -> second write has addr BASE+1, din[7:0]=0xCC, be=01, issued during FLUSH. done follows it.
- Start at odd addr 5 (0x5A), then addr 8 -> writes: word 2 be=10 din[15:8]=0x5A; word 4 be=01 (flushed at end).
- mem_ack held off 40 cycles with a continuous byte stream -> clkref_n rises when count reaches DEPTH-3. overflow stays 0, no bytes lost, final byte_count equals bytes sent.
- Download with ioctl_index != INDEX -> no mem_req, busy=0, done=0, byte_count unchanged.
- reset asserted while mem_req=1 mid-download -> next cycle mem_req=0, busy=0. A subsequent download completes normally from byte_count=0.
